dma_burst_responder: RTL and testbench
======================================

DMA_BURST_RESPONDER -- requirements
Module: dma_burst_responder

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits (signed data).
REQ-002 Parameter BURST_LEN, default 25, number of words returned per read.
REQ-003 Parameter MEM_DEPTH, default 4096, number of words of storage; SHALL be a power of two.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  request strobe; sampled only in IDLE.
REQ-007 RW  input  1  1 = burst read, 0 = single-word write.
REQ-008 address  input  16  word address (read base, or write target).
REQ-009 inputDATA  input  DATA_W  write data.
REQ-010 outputData  output  BURST_LEN x DATA_W (signed, [0:BURST_LEN-1])  read window; element i = mem[base+i].
REQ-011 busy  output  1  high while a read burst is in progress.
REQ-012 dataValid  output  1  one-cycle pulse when outputData holds a new complete window.
REQ-013 writeAck  output  1  one-cycle pulse the cycle after a write is committed.
REQ-014 rangeErr  output  1  sticky out-of-range flag (present only with RESP_RANGE_CHECK_EN).

Function
REQ-015 FSM states IDLE, READ, DONE; reset state IDLE.
REQ-016 IDLE, enable=1, RW=0: mem[address] <= inputDATA that edge; writeAck=1 next cycle; stay IDLE.
REQ-017 IDLE, enable=1, RW=1: latch base=address, clear index counter, go READ; busy=1 from next cycle.
REQ-018 READ: one word per cycle from single-port storage into a staging buffer, index 0..BURST_LEN-1; after index BURST_LEN-1 go DONE.
REQ-019 DONE: copy staging buffer to outputData in one edge, dataValid=1 for exactly that cycle, busy=0, return IDLE.
REQ-020 Read latency: enable sampled at edge N -> dataValid high in cycle N+BURST_LEN+1 (26 cycles for default).
REQ-021 outputData SHALL hold its last value between bursts; never partially updated.
REQ-022 enable while busy or in DONE SHALL be ignored (no queuing); writes during a burst are dropped.
REQ-023 Address arithmetic base+i SHALL be 16-bit unsigned; index counter width = clog2(BURST_LEN).
REQ-024 Address >= MEM_DEPTH, or burst crossing the top of memory: behaviour per REQ-029/030.
REQ-025 Write to an address just read in the same burst does not occur (REQ-022); no read-after-write hazard exists.

Reset
REQ-026 On reset: state IDLE, busy=0, dataValid=0, writeAck=0, rangeErr=0, outputData all zero, staging buffer and counters cleared.
REQ-027 Reset mid-burst SHALL abort the burst with no dataValid; memory contents SHALL NOT be reset.

Configuration
REQ-028 Macro RESP_RANGE_CHECK_EN selects address bounds checking.
REQ-029 Defined: any word address >= MEM_DEPTH returns 0 in that slot, rangeErr set and held until reset; out-of-range writes discarded, writeAck still pulses, rangeErr set.
REQ-030 Not defined: rangeErr port absent; addresses truncated to clog2(MEM_DEPTH) bits (wrap modulo MEM_DEPTH) for reads and writes.

Structure
REQ-031 Shared package dma_pkg SHALL hold DATA_W, BURST_LEN defaults, the state enum type and the word typedef, shared with biases_repeater and testbenches.
REQ-032 Storage SHALL be a sub-module dma_word_ram (single port, synchronous write, one-cycle read); FSM and staging stay in dma_burst_responder.

Verification
REQ-033 Write 7 to addr 100, then -3 to 101, 12 to 102 -> writeAck pulse after each; burst read at 100 -> after 26 cycles outputData[0..2]=7,-3,12, dataValid one cycle.
REQ-034 Write 5 to addr 150, read 150, assert enable with RW=1 again at cycle 10 -> ignored, single dataValid at cycle 26, busy=1 cycles 1..25.
REQ-035 Reset at cycle 12 of a burst -> busy=0, dataValid never pulses, outputData zero; subsequent read of addr 100 returns 7.
REQ-036 (RESP_RANGE_CHECK_EN) read at base 4090 -> slots 0..5 = mem[4090..4095], slots 6..24 = 0, rangeErr=1 until reset.
REQ-037 (no macro) write 9 to addr 4096 -> mem[0]=9; read at 4095 -> outputData[1]=9.

Source files
------------

// File: rtl/dma_burst_responder_pkg.sv
// dma_pkg: shared word width, burst length, storage depth, FSM state enum and word type
package dma_pkg;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_LEN = 25;
    localparam int DEF_MEM_DEPTH = 4096;
    typedef enum logic [1:0] {IDLE, READ, DONE} dmaState_t;
    typedef logic signed [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/dma_burst_responder_if.sv
// dma_burst_responder_if: request/response bus of the burst responder
//   master: drives enable, RW, address, inputDATA; receives outputData, busy, dataValid, writeAck
//   slave : the responder side of the same signals
//   rangeErr exists only when RESP_RANGE_CHECK_EN is defined
interface dma_burst_responder_if
    import dma_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN
);
    logic                     enable;
    logic                     RW;
    logic [15:0]              address;
    logic signed [DATA_W-1:0] inputDATA;
    logic signed [DATA_W-1:0] outputData [0:BURST_LEN-1];
    logic                     busy;
    logic                     dataValid;
    logic                     writeAck;
`ifdef RESP_RANGE_CHECK_EN
    logic                     rangeErr;
    modport master (output enable, RW, address, inputDATA,
                    input outputData, busy, dataValid, writeAck, rangeErr);
    modport slave  (input enable, RW, address, inputDATA,
                    output outputData, busy, dataValid, writeAck, rangeErr);
`else
    modport master (output enable, RW, address, inputDATA,
                    input outputData, busy, dataValid, writeAck);
    modport slave  (input enable, RW, address, inputDATA,
                    output outputData, busy, dataValid, writeAck);
`endif
endinterface

// File: rtl/dma_burst_responder_ram.sv
// dma_word_ram: single-port word storage, synchronous write, registered one-cycle read
//   clk, we, addr, wrData in; rdData = mem[addr] of the previous edge
module dma_word_ram #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic signed [DATA_W-1:0]     wrData,
    output logic signed [DATA_W-1:0]     rdData
);
    logic signed [DATA_W-1:0] mem [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wrData;
        rdData <= mem[addr];
    end
endmodule

// File: rtl/dma_burst_responder.sv
// dma_burst_responder: single-word writes and BURST_LEN-word burst reads over a staging buffer
//   clk, reset (sync, active high); bus: dma_burst_responder_if.slave
//   RESP_RANGE_CHECK_EN: out-of-range words read as 0, writes dropped, sticky rangeErr;
//   otherwise addresses wrap modulo MEM_DEPTH
module dma_burst_responder
    import dma_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input logic                  clk,
    input logic                  reset,
    dma_burst_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    dmaState_t                state;
    logic [15:0]              base;
    logic [15:0]              addrFull;
    logic [IW-1:0]            idx;
    logic signed [DATA_W-1:0] stage [0:BURST_LEN-1];
    logic signed [DATA_W-1:0] rdData;
    logic                     wrReq;
    logic                     rdReq;
    logic                     we;
    logic                     oob;
    logic                     oobQ;
    assign wrReq = state == IDLE && bus.enable && !bus.RW;
    assign rdReq = state == IDLE && bus.enable && bus.RW;
    // word 0 is fetched on the accepting edge, so READ presents the next word each cycle
    assign addrFull = state == IDLE ? bus.address : base + 16'(idx) + 16'd1;
`ifdef RESP_RANGE_CHECK_EN
    assign oob = |(addrFull >> AW);
    assign we  = wrReq && !oob;
`else
    logic unusedHighAddr;
    assign unusedHighAddr = ^addrFull[15:AW];
    assign oob = 1'b0;
    assign we  = wrReq;
`endif
    dma_word_ram #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) ram (
        .clk(clk),
        .we(we),
        .addr(addrFull[AW-1:0]),
        .wrData(bus.inputDATA),
        .rdData(rdData)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base           <= '0;
            idx            <= '0;
            oobQ           <= 1'b0;
            stage          <= '{default: '0};
            bus.outputData <= '{default: '0};
            bus.busy       <= 1'b0;
            bus.dataValid  <= 1'b0;
            bus.writeAck   <= 1'b0;
`ifdef RESP_RANGE_CHECK_EN
            bus.rangeErr   <= 1'b0;
`endif
        end else begin
            bus.busy      <= state == READ;
            bus.dataValid <= state == DONE;
            bus.writeAck  <= wrReq;
            // tracks whether the word now in rdData came from an out-of-range address
            oobQ          <= oob;
`ifdef RESP_RANGE_CHECK_EN
            if ((state == READ && oobQ) || (wrReq && oob)) bus.rangeErr <= 1'b1;
`endif
            case (state)
                IDLE: if (rdReq) begin
                    base  <= bus.address;
                    idx   <= '0;
                    state <= READ;
                end
                READ: begin
                    stage[idx] <= oobQ ? '0 : rdData;
                    idx        <= idx + 1'b1;
                    if (idx == IW'(BURST_LEN - 1)) state <= DONE;
                end
                DONE: begin
                    bus.outputData <= stage;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_burst_responder.sv
// tb_dma_burst_responder: scoreboard bench for dma_burst_responder (default parameters)
module tb_dma_burst_responder;
    import dma_pkg::*;
    localparam int BL  = DEF_BURST_LEN;
    localparam int MEM = DEF_MEM_DEPTH;
    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    int    nTests = 0;
    int    nFail  = 0;
    word_t mdl [int];
    int    expSlot [$];
    word_t expVal  [$];
    int    expCnt  [$];

    dma_burst_responder_if bus();
    dma_burst_responder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic doWrite(input int a, input word_t d);
        bus.enable = 1'b1; bus.RW = 1'b0; bus.address = 16'(a); bus.inputDATA = d;
        tick();
        bus.enable = 1'b0;
`ifdef RESP_RANGE_CHECK_EN
        if (a < MEM) mdl[a] = d;
`else
        mdl[a % MEM] = d;
`endif
        nTests++;
        if (bus.writeAck !== 1'b1) begin
            nFail++; $display("FAIL writeAck_pulse addr %0d: got %b want 1", a, bus.writeAck);
        end
        tick();
        nTests++;
        if (bus.writeAck !== 1'b0) begin
            nFail++; $display("FAIL writeAck_one_cycle addr %0d: got %b want 0", a, bus.writeAck);
        end
    endtask

    task automatic pushWindow(input int a);
        int n = 0;
        for (int i = 0; i < BL; i++) begin
            int x; bit known; word_t v;
            x = (a + i) & 'hFFFF;
            known = 1'b0; v = '0;
`ifdef RESP_RANGE_CHECK_EN
            if (x >= MEM) known = 1'b1;
            else if (mdl.exists(x)) begin known = 1'b1; v = mdl[x]; end
`else
            x = x % MEM;
            if (mdl.exists(x)) begin known = 1'b1; v = mdl[x]; end
`endif
            if (known) begin expSlot.push_back(i); expVal.push_back(v); n++; end
        end
        expCnt.push_back(n);
    endtask

    task automatic popWindow(input string tag, input bit cmp);
        int n;
        n = expCnt.pop_front();
        for (int j = 0; j < n; j++) begin
            int s; word_t v;
            s = expSlot.pop_front();
            v = expVal.pop_front();
            if (cmp) begin
                nTests++;
                if (bus.outputData[s] !== v) begin
                    nFail++; $display("FAIL %s slot %0d: got %0d want %0d", tag, s, bus.outputData[s], v);
                end
            end
        end
    endtask

    task automatic readBurst(input int a, input string tag);
        int lat = 0;
        bus.enable = 1'b1; bus.RW = 1'b1; bus.address = 16'(a);
        tick();
        bus.enable = 1'b0;
        pushWindow(a);
        for (int c = 1; c <= 2 * BL; c++) begin
            tick();
            if (bus.dataValid === 1'b1) begin lat = c; break; end
        end
        nTests++;
        if (lat != BL + 1) begin
            nFail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, BL + 1);
        end
        popWindow(tag, lat != 0);
    endtask

    task automatic test_reset();
        int nz = 0;
        applyReset();
        for (int i = 0; i < BL; i++) if (bus.outputData[i] !== '0) nz++;
        nTests += 4;
        if (bus.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.dataValid !== 1'b0) begin nFail++; $display("FAIL reset_dataValid: got %b want 0", bus.dataValid); end
        if (bus.writeAck !== 1'b0) begin nFail++; $display("FAIL reset_writeAck: got %b want 0", bus.writeAck); end
        if (nz != 0) begin nFail++; $display("FAIL reset_outputData: %0d nonzero slots want 0", nz); end
`ifdef RESP_RANGE_CHECK_EN
        nTests++;
        if (bus.rangeErr !== 1'b0) begin nFail++; $display("FAIL reset_rangeErr: got %b want 0", bus.rangeErr); end
`endif
    endtask

    task automatic prefill();
        for (int a = 0; a <= 30; a++) doWrite(a, word_t'($urandom));
        for (int a = 100; a <= 180; a++) doWrite(a, word_t'($urandom));
        for (int a = 4080; a < MEM; a++) doWrite(a, word_t'($urandom));
    endtask

    task automatic test_write_read();
        doWrite(100, 7);
        doWrite(101, -3);
        doWrite(102, 12);
        readBurst(100, "write_read");
        nTests += 3;
        if (bus.outputData[0] !== 16'sd7) begin nFail++; $display("FAIL write_read_w0: got %0d want 7", bus.outputData[0]); end
        if (bus.outputData[1] !== -16'sd3) begin nFail++; $display("FAIL write_read_w1: got %0d want -3", bus.outputData[1]); end
        if (bus.outputData[2] !== 16'sd12) begin nFail++; $display("FAIL write_read_w2: got %0d want 12", bus.outputData[2]); end
    endtask

    task automatic test_ignore_while_busy();
        int dv = 0, dvAt = 0, busyBad = 0, ackBad = 0;
        doWrite(150, 5);
        bus.enable = 1'b1; bus.RW = 1'b1; bus.address = 16'd150;
        tick();
        bus.enable = 1'b0;
        pushWindow(150);
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin bus.enable = 1'b1; bus.RW = 1'b0; bus.address = 16'd150; bus.inputDATA = 16'sd99; end
            if (c == 10) begin bus.enable = 1'b1; bus.RW = 1'b1; bus.address = 16'd160; end
            tick();
            bus.enable = 1'b0;
            if (bus.writeAck !== 1'b0) ackBad++;
            if (bus.dataValid === 1'b1) begin
                dv++;
                if (dvAt == 0) begin dvAt = c; popWindow("ignore_busy", 1'b1); end
            end
            if ((c <= BL) != (bus.busy === 1'b1)) busyBad++;
        end
        if (dvAt == 0) popWindow("ignore_busy", 1'b0);
        nTests += 4;
        if (dv != 1) begin nFail++; $display("FAIL ignore_busy_pulses: got %0d want 1", dv); end
        if (dvAt != BL + 1) begin nFail++; $display("FAIL ignore_busy_latency: got %0d want %0d", dvAt, BL + 1); end
        if (busyBad != 0) begin nFail++; $display("FAIL ignore_busy_window: %0d bad cycles want 0", busyBad); end
        if (ackBad != 0) begin nFail++; $display("FAIL ignore_busy_write_dropped: %0d acks want 0", ackBad); end
    endtask

    task automatic test_reset_mid_burst();
        int nz = 0, dv = 0;
        bus.enable = 1'b1; bus.RW = 1'b1; bus.address = 16'd100;
        tick();
        bus.enable = 1'b0;
        pushWindow(100);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        popWindow("aborted", 1'b0);
        for (int i = 0; i < BL; i++) if (bus.outputData[i] !== '0) nz++;
        nTests += 2;
        if (bus.busy !== 1'b0) begin nFail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (nz != 0) begin nFail++; $display("FAIL abort_outputData: %0d nonzero slots want 0", nz); end
        repeat (2 * BL) begin tick(); if (bus.dataValid !== 1'b0) dv++; end
        nTests++;
        if (dv != 0) begin nFail++; $display("FAIL abort_dataValid: %0d pulses want 0", dv); end
        readBurst(100, "after_abort");
        nTests++;
        if (bus.outputData[0] !== 16'sd7) begin nFail++; $display("FAIL after_abort_w0: got %0d want 7", bus.outputData[0]); end
    endtask

    task automatic test_back_to_back();
        word_t oldVal;
        readBurst(140, "b2b_a");
        readBurst(160, "b2b_b");
        oldVal = mdl[160];
        doWrite(160, oldVal + 16'sd1);
        repeat (5) tick();
        nTests++;
        if (bus.outputData[0] !== oldVal) begin
            nFail++; $display("FAIL hold_between_bursts: got %0d want %0d", bus.outputData[0], oldVal);
        end
    endtask

`ifdef RESP_RANGE_CHECK_EN
    task automatic test_range();
        applyReset();
        readBurst(4090, "range_window");
        repeat (5) tick();
        nTests++;
        if (bus.rangeErr !== 1'b1) begin nFail++; $display("FAIL range_read_flag: got %b want 1", bus.rangeErr); end
        applyReset();
        nTests++;
        if (bus.rangeErr !== 1'b0) begin nFail++; $display("FAIL range_flag_reset: got %b want 0", bus.rangeErr); end
        doWrite(904, 33);
        doWrite(5000, 44);
        nTests++;
        if (bus.rangeErr !== 1'b1) begin nFail++; $display("FAIL range_write_flag: got %b want 1", bus.rangeErr); end
        readBurst(904, "oob_write_discard");
        nTests++;
        if (bus.outputData[0] !== 16'sd33) begin nFail++; $display("FAIL oob_write_w0: got %0d want 33", bus.outputData[0]); end
    endtask
`else
    task automatic test_wrap();
        doWrite(4096, 9);
        readBurst(4095, "wrap");
        nTests++;
        if (bus.outputData[1] !== 16'sd9) begin nFail++; $display("FAIL wrap_w1: got %0d want 9", bus.outputData[1]); end
    endtask
`endif

    initial begin
        bus.enable = 1'b0; bus.RW = 1'b0; bus.address = '0; bus.inputDATA = '0;
        test_reset();
        prefill();
        test_write_read();
        test_ignore_while_busy();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef RESP_RANGE_CHECK_EN
        test_range();
`else
        test_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
